// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state type and default widths for the timer sequencing engine
package timer_ctrl_pkg;

    typedef enum logic [1:0] {TMR_IDLE, TMR_LOAD, TMR_RUN} timer_state_t;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider emitting one tick every (presc+1) cycles while not cleared
module timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = !clr && cnt == presc;

    // A count already above a lowered presc keeps going and wraps naturally at 2^PRESC_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || cnt == presc)
            cnt <= '0;
        else
            cnt <= cnt + PRESC_W'(1);
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: IDLE/LOAD/RUN sequencer driving TCR, the sticky TIR.ZERO flag and the timer irq
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cnt_ena,
    input  logic               cnt_udt,
    input  logic               cnt_ien,
    input  logic [PRESC_W-1:0] presc,
    input  logic [CNT_W-1:0]   tlr_val,
    input  logic               tcr_wr,
    input  logic [CNT_W-1:0]   tcr_wdata,
    input  logic               tir_clr,
    output logic [CNT_W-1:0]   tcr_val,
    output logic               tir_zero,
    output logic               irq,
    output logic               running
);

    timer_state_t     state, state_nxt;
    logic             tick, take, term, evt;
    logic [CNT_W-1:0] tcr_nxt;

    timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != TMR_RUN),
        .presc (presc),
        .tick  (tick)
    );

    assign running = state == TMR_RUN;

    // A software TCR write swallows the tick of its cycle, so no terminal event can fire then
    always_comb begin
        state_nxt = cnt_ena ? (state == TMR_IDLE ? TMR_LOAD : TMR_RUN) : TMR_IDLE;
        take      = state == TMR_RUN && cnt_ena && tick && !tcr_wr;
        term      = cnt_udt ? tcr_val == '0 : tcr_val >= tlr_val;
        evt       = take && term;
        tcr_nxt   = tcr_wr ? tcr_wdata :
                    state == TMR_LOAD ? tlr_val :
                    !take ? tcr_val :
                    cnt_udt ? (term ? tlr_val : tcr_val - CNT_W'(1)) :
                              (term ? '0 : tcr_val + CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TMR_IDLE;
            tcr_val  <= '0;
            tir_zero <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            tcr_val  <= tcr_nxt;
            tir_zero <= evt || (tir_zero && !tir_clr);
            irq      <= tir_zero && cnt_ien;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized traffic checked against a cycle-level reference model
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_ena = 1'b0;
    logic        cnt_udt = 1'b0;
    logic        cnt_ien = 1'b0;
    logic [7:0]  presc = '0;
    logic [31:0] tlr_val = '0;
    logic        tcr_wr = 1'b0;
    logic [31:0] tcr_wdata = '0;
    logic        tir_clr = 1'b0;
    logic [31:0] tcr_val;
    logic        tir_zero;
    logic        irq;
    logic        running;

    int n_chk = 0;
    int n_pass = 0;

    // reference model: phase 0 = stopped, 1 = reload pending, 2 = counting
    int          ph;
    int          mp;
    logic [31:0] m_tcr;
    bit          m_tir, m_irq;

    timer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_ena   (cnt_ena),
        .cnt_udt   (cnt_udt),
        .cnt_ien   (cnt_ien),
        .presc     (presc),
        .tlr_val   (tlr_val),
        .tcr_wr    (tcr_wr),
        .tcr_wdata (tcr_wdata),
        .tir_clr   (tir_clr),
        .tcr_val   (tcr_val),
        .tir_zero  (tir_zero),
        .irq       (irq),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        ph = 0;
        mp = 0;
        m_tcr = '0;
        m_tir = 0;
        m_irq = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_tcr"}, tcr_val, m_tcr);
        check({tag, "_tir"}, {31'd0, tir_zero}, {31'd0, m_tir});
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
        check({tag, "_run"}, {31'd0, running}, {31'd0, ph == 2});
    endtask

    // one clock: advance the model by the timer's rules using the inputs held across the edge
    task automatic step(input string tag);
        bit tk, ev;
        logic [31:0] nt;
        @(posedge clk);
        ev = 0;
        tk = ph == 2 && cnt_ena && mp == int'(presc);
        nt = m_tcr;
        if (tcr_wr)
            nt = tcr_wdata;
        else if (ph == 1)
            nt = tlr_val;
        else if (tk) begin
            if (cnt_udt) begin
                if (m_tcr == 0) begin nt = tlr_val; ev = 1; end
                else nt = m_tcr - 1;
            end else begin
                if (m_tcr >= tlr_val) begin nt = 0; ev = 1; end
                else nt = m_tcr + 1;
            end
        end
        m_irq = m_tir && cnt_ien;
        m_tir = ev || (m_tir && !tir_clr);
        mp = (ph == 2) ? ((mp == int'(presc)) ? 0 : (mp + 1) % 256) : 0;
        ph = !cnt_ena ? 0 : (ph == 0 ? 1 : 2);
        m_tcr = nt;
        #1;
        check_all(tag);
    endtask

    task automatic async_rst();
        #2 rst = 1'b1;
        #1;
        check("arst_tcr", tcr_val, 32'd0);
        check("arst_tir", {31'd0, tir_zero}, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_run", {31'd0, running}, 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] seq1 [5];
        seq1 = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
        model_reset();
        #12;
        check("rst_tcr", tcr_val, 32'd0);
        check("rst_tir", {31'd0, tir_zero}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_run", {31'd0, running}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // down count, presc 0, tlr 3: LOAD, then 3,2,1,0,3 with the event on the reload
        cnt_udt = 1'b1; cnt_ien = 1'b1; presc = 8'd0; tlr_val = 32'd3; cnt_ena = 1'b1;
        step("t1");
        for (int i = 0; i < 5; i++) begin
            step("t1");
            check("t1_seq", tcr_val, seq1[i]);
        end
        check("t1_flag", {31'd0, tir_zero}, 32'd1);
        step("t1");
        check("t1_irq", {31'd0, irq}, 32'd1);

        // up count, presc 1, tlr 2, irq masked
        cnt_udt = 1'b0; cnt_ien = 1'b0; presc = 8'd1; tlr_val = 32'd2;
        tir_clr = 1'b1; step("t2"); tir_clr = 1'b0;
        for (int i = 0; i < 20; i++) step("t2");
        check("t2_irq_masked", {31'd0, irq}, 32'd0);

        // TCR write in IDLE is held
        cnt_ena = 1'b0; step("t4");
        tcr_wr = 1'b1; tcr_wdata = 32'h10; step("t4"); tcr_wr = 1'b0;
        for (int i = 0; i < 3; i++) step("t4");
        check("t4_idle_hold", tcr_val, 32'h10);

        // TLR lowered under a running up count: next tick terminates
        async_rst();
        cnt_udt = 1'b0; presc = 8'd0; tlr_val = 32'd100; cnt_ena = 1'b1;
        for (int i = 0; i < 200 && !(ph == 2 && m_tcr == 32'd50); i++) step("t6a");
        check("t6_reach50", tcr_val, 32'd50);
        tlr_val = 32'd3;
        step("t6b");
        check("t6_wrap", tcr_val, 32'd0);
        check("t6_evt", {31'd0, tir_zero}, 32'd1);
        presc = 8'd7;
        for (int i = 0; i < 20 && mp != 5; i++) step("t6c");
        presc = 8'd0;
        for (int i = 0; i < 270; i++) step("t6d");

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            cnt_ena = $urandom_range(0, 24) != 0;
            if ($urandom_range(0, 39) == 0) cnt_udt = ~cnt_udt;
            if ($urandom_range(0, 29) == 0) cnt_ien = ~cnt_ien;
            if ($urandom_range(0, 59) == 0) presc = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) tlr_val = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 9);
            tcr_wr = $urandom_range(0, 29) == 0;
            tcr_wdata = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 12);
            tir_clr = $urandom_range(0, 7) == 0;
            step("rnd");
            if ($urandom_range(0, 499) == 0) async_rst();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
